// File: rtl/spi_slave_rx_if.sv
// Bundle of the SPI serial inputs and the deserialised receive outputs.
// The slave modport is the receive endpoint; the master modport is the SPI
// source plus the consumer of the received words.
interface spi_slave_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;
    logic [7:0]        word_count;

    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy,
        output word_count
    );

    modport master (
        output sclk,
        output cs,
        output mosi,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy,
        input  word_count
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI receive endpoint, CPOL=0 / CPHA=0, MSB first. All SPI pins are
// asynchronous and are synchronised into clk; words are presented with a
// one-cycle rx_valid strobe and partial words are reported on frame_err.
module spi_slave_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_rx_if.slave  bus
);

    localparam int unsigned             CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]        LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_e;

    // Synchroniser chains, all the same depth so mosi stays aligned with sclk.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    // Marks when the chains hold real samples rather than their reset values.
    logic [SYNC_STAGES-1:0] sync_fill_q;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sync_live;

    logic sclk_d_q;
    logic cs_d_q;
    logic armed_q;

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;
    logic frame_start;

    state_e              state_q,      state_d;
    logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0]   shift_q,      shift_d;
    logic [DATA_W-1:0]   rx_data_q,    rx_data_d;
    logic                rx_valid_q,   rx_valid_d;
    logic                frame_err_q,  frame_err_d;
    logic [7:0]          word_count_q, word_count_d;

    logic [DATA_W-1:0]   shift_next;

    // Input synchronisers and the fill tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sync_fill_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sync_fill_q <= {sync_fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sync_live = sync_fill_q[SYNC_STAGES-1];

    // Edge-detect delays, plus the arm flag: a frame may only start after cs
    // has genuinely been seen high, so cs held low across reset cannot open a
    // mis-aligned frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d_q <= 1'b0;
            cs_d_q   <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            sclk_d_q <= sclk_s;
            cs_d_q   <= cs_s;
            if (sync_live && cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sclk_rise   = sclk_s & ~sclk_d_q;
    assign cs_fall     = ~cs_s & cs_d_q;
    assign cs_rise     = cs_s & ~cs_d_q;
    assign frame_start = cs_fall & armed_q;

    assign shift_next  = {shift_q[DATA_W-2:0], mosi_s};

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            word_count_q <= word_count_d;
        end
    end

    // Next-state logic: framing on cs, bit capture on sclk rises.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        word_count_d = word_count_q;

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d      = StActive;
                    bit_cnt_d    = '0;
                    shift_d      = '0;
                    word_count_d = '0;
                end
            end
            StActive: begin
                // cs_rise takes priority over a coincident sclk edge.
                if (cs_rise) begin
                    state_d     = StIdle;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end else if (sclk_rise) begin
                    shift_d = shift_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = shift_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        if (word_count_q != 8'hFF) begin
                            word_count_d = word_count_q + 8'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q == StActive);
    assign bus.word_count = word_count_q;

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI receive endpoint (CPOL=0, CPHA=0, MSB first) that deserialises the `sclk`/`cs`/`mosi` stream produced by the team's SPI master into parallel bytes. All three SPI inputs are asynchronous to `clk` and are brought into the system clock domain through synchronisers. Each completed word is presented on `rx_data` with a one-cycle `rx_valid` strobe. Chip-select framing is checked, and a partial word is reported on `frame_err`.

## Interface
- `DATA_W`, default 8: word width; bits are received MSB first.
- `SYNC_STAGES`, default 2: flop depth of each input synchroniser; minimum 2.
- `clk` input, 1: system clock; the only clock in the block.
- `rst` input, 1: reset, synchronous, active-high.
- `sclk` input, 1: SPI serial clock, asynchronous, idle low.
- `cs` input, 1: chip select, asynchronous, active-low.
- `mosi` input, 1: serial data, asynchronous.
- `rx_data` output, DATA_W: last completed word; held until the next word completes.
- `rx_valid` output, 1: one-cycle strobe; `rx_data` is new on this cycle.
- `frame_err` output, 1: one-cycle strobe; `cs` deasserted with a partial word received.
- `busy` output, 1: high while in ACTIVE.
- `word_count` output, 8: words completed in the current frame; saturates at 255.

## Operation
- **Synchronisers**
  - `sclk`, `cs` and `mosi` each pass through a SYNC_STAGES-deep chain, giving `sclk_s`, `cs_s` and `mosi_s`. All three chains have equal depth so data stays aligned with its clock edge.
  - Chain reset values: `sclk` 0, `cs` 1, `mosi` 0.
- **Edge detect**
  - `sclk_d` and `cs_d` are one-cycle delays of the synchronised signals.
  - `sclk_rise = sclk_s & ~sclk_d`.
  - `cs_fall = ~cs_s & cs_d`.
  - `cs_rise = cs_s & ~cs_d`.
- **FSM states**
  - IDLE, which is the reset state.
    - Goes to ACTIVE on `cs_fall`: clears `bit_cnt`, `shift` and `word_count`.
    - `sclk_rise` in IDLE is ignored.
  - ACTIVE
    - On `sclk_rise` (and no `cs_rise`), `shift <= {shift[DATA_W-2:0], mosi_s}` and `bit_cnt` increments.
    - When `bit_cnt == DATA_W-1` at a `sclk_rise`:
      - `rx_data <= {shift[DATA_W-2:0], mosi_s}` and `rx_valid <= 1`.
      - `bit_cnt` wraps to 0 and `word_count` increments, saturating at 255.
    - Multiple words per frame are allowed.
    - On `cs_rise`, go to IDLE. If `bit_cnt != 0`, pulse `frame_err` and discard the partial `shift`. `rx_data` is unchanged.
- **Widths**
  - `bit_cnt` is `$clog2(DATA_W)` bits and never exceeds DATA_W-1.
- **Boundary conditions**
  - `sclk_rise` and `cs_rise` in the same cycle: `cs_rise` wins and the edge is not sampled.
  - `cs` held low through reset: the block stays in IDLE until a fresh `cs_fall`, so words are never mis-aligned.
  - `cs_rise` exactly after a complete word (`bit_cnt == 0`): no `frame_err`.
  - `sclk` toggling while `cs` is high: no effect on any output.
- **Reset values**
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `busy` = 0, `word_count` = 0.
  - State = IDLE; all shift/counter registers = 0.

## Timing
- **Input latency:** a raw input change reaches `*_s` after SYNC_STAGES clk edges. The edge detect adds no further cycle; the `sclk_rise` flag is combinational from `sclk_s`/`sclk_d`.
- **Word latency:** `rx_valid` and `rx_data` update on the clk edge SYNC_STAGES+1 cycles after the final raw `sclk` rise is first sampled.
- **Strobe widths:** `rx_valid` and `frame_err` are each exactly one cycle wide.
- **Minimum SCLK timing:**
  - `sclk` high time and low time must each be at least SYNC_STAGES+1 clk periods.
  - `mosi` must be stable from at least SYNC_STAGES+1 clk before each `sclk` rise until SYNC_STAGES+1 clk after it.
  - The master's sclk of clk/8 meets these limits with margin.
- **CS setup:** `cs` must fall at least SYNC_STAGES+2 clk before the first `sclk` rise of a frame.
- **`busy`:** rises the cycle after `cs_fall` is detected and falls the cycle after `cs_rise` is detected.

## Test plan
1. **Single byte:** `cs` low, 8 rising `sclk` edges at clk/8 carrying 0xA3 MSB first, then `cs` high.
   - `rx_valid` pulses once with `rx_data` = 0xA3.
   - `word_count` = 1 and `frame_err` stays 0.
2. **Back-to-back words:** one frame carrying 0xA3, 0x5C, 0xFF.
   - Three `rx_valid` pulses with data 0xA3, 0x5C, 0xFF in order.
   - `word_count` reads 3 at the end of the frame.
3. **Truncated frame:** `cs` rises after 5 bits of 0xA3.
   - `frame_err` pulses once and there is no `rx_valid`.
   - `rx_data` keeps its previous value.
   - The next full frame of 0x3C is received correctly.
4. **Out-of-frame clocking:** `sclk` toggles 16 times with `cs` high.
   - No `rx_valid`, no `frame_err`, `busy` stays 0.
5. **Reset mid-frame:** assert `rst` for 1 cycle after 3 bits while `cs` stays low; continue clocking, then raise `cs`.
   - All outputs are 0 after reset.
   - No `rx_valid` or `frame_err` until a new `cs_fall`.
   - The following 0xA3 frame is received correctly.
6. **Collision:** the final (8th) `sclk` rise and `cs` rise reach the synchroniser outputs in the same cycle.
   - `frame_err` pulses and there is no `rx_valid`.
